// File: rtl/ahb_master_mux2_pkg.sv
// ahb_master_mux2_pkg: shared AHB-Lite encodings and port id type for the 2:1 master mux
package ahb_master_mux2_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic HRESP_OKAY = 1'b0;
  typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_e;
endpackage

// File: rtl/ahb_master_mux2_addr_hold.sv
// ahb_master_mux2_addr_hold: per-port parked address phase (pend flag + ADDR/WRITE/SIZE) and candidate mux
//   HCLK/HRESETn clock and async active-low reset; live/grant request and grant of this port;
//   live_* current address phase; pend parked flag; cand pend|live; c_* candidate address phase
module ahb_master_mux2_addr_hold #(
  parameter int AW = 32
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          live,
  input  logic          grant,
  input  logic [AW-1:0] live_haddr,
  input  logic          live_hwrite,
  input  logic [2:0]    live_hsize,
  output logic          pend,
  output logic          cand,
  output logic [AW-1:0] c_haddr,
  output logic          c_hwrite,
  output logic [2:0]    c_hsize
);
  logic [AW-1:0] h_haddr;
  logic          h_hwrite;
  logic [2:0]    h_hsize;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      pend     <= 1'b0;
      h_haddr  <= '0;
      h_hwrite <= 1'b0;
      h_hsize  <= '0;
    end else if (grant) begin
      pend <= 1'b0;
    end else if (live) begin
      pend     <= 1'b1;
      h_haddr  <= live_haddr;
      h_hwrite <= live_hwrite;
      h_hsize  <= live_hsize;
    end
  always_comb begin
    cand     = pend | live;
    c_haddr  = pend ? h_haddr : live_haddr;
    c_hwrite = pend ? h_hwrite : live_hwrite;
    c_hsize  = pend ? h_hsize : live_hsize;
  end
endmodule

// File: rtl/ahb_master_mux2.sv
// ahb_master_mux2: 2:1 AHB-Lite master mux (port 0 CPU, port 1 DMAC), losers parked and stalled via HREADY
//   S0_*/S1_* upstream master ports; M_* downstream bus; HCLK/HRESETn async active-low reset.
//   AHB_MMUX_RR_EN defined: round-robin on ties; undefined: fixed priority, port 0 first.
module ahb_master_mux2
  import ahb_master_mux2_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic [AW-1:0] S0_HADDR,
  input  logic [1:0]    S0_HTRANS,
  input  logic          S0_HWRITE,
  input  logic [2:0]    S0_HSIZE,
  input  logic [DW-1:0] S0_HWDATA,
  output logic          S0_HREADY,
  output logic [DW-1:0] S0_HRDATA,
  output logic          S0_HRESP,
  input  logic [AW-1:0] S1_HADDR,
  input  logic [1:0]    S1_HTRANS,
  input  logic          S1_HWRITE,
  input  logic [2:0]    S1_HSIZE,
  input  logic [DW-1:0] S1_HWDATA,
  output logic          S1_HREADY,
  output logic [DW-1:0] S1_HRDATA,
  output logic          S1_HRESP,
  output logic [AW-1:0] M_HADDR,
  output logic [1:0]    M_HTRANS,
  output logic          M_HWRITE,
  output logic [2:0]    M_HSIZE,
  output logic [DW-1:0] M_HWDATA,
  input  logic          M_HREADY,
  input  logic [DW-1:0] M_HRDATA,
  input  logic          M_HRESP
);
  logic          live0, live1, pend0, pend1, cand0, cand1, grant, w, dvalid;
  logic [AW-1:0] c0_haddr, c1_haddr, last_haddr;
  logic          c0_hwrite, c1_hwrite, last_hwrite;
  logic [2:0]    c0_hsize, c1_hsize, last_hsize;
  port_e         owner;
  logic          unused_htrans;
  assign unused_htrans = S0_HTRANS[0] ^ S1_HTRANS[0];
  assign live0 = S0_HTRANS[1] & S0_HREADY;
  assign live1 = S1_HTRANS[1] & S1_HREADY;
  assign grant = M_HREADY & (cand0 | cand1);
  ahb_master_mux2_addr_hold #(.AW(AW)) u_hold0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .live(live0), .grant(grant & !w),
    .live_haddr(S0_HADDR), .live_hwrite(S0_HWRITE), .live_hsize(S0_HSIZE),
    .pend(pend0), .cand(cand0), .c_haddr(c0_haddr), .c_hwrite(c0_hwrite), .c_hsize(c0_hsize)
  );
  ahb_master_mux2_addr_hold #(.AW(AW)) u_hold1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .live(live1), .grant(grant & w),
    .live_haddr(S1_HADDR), .live_hwrite(S1_HWRITE), .live_hsize(S1_HSIZE),
    .pend(pend1), .cand(cand1), .c_haddr(c1_haddr), .c_hwrite(c1_hwrite), .c_hsize(c1_hsize)
  );
`ifdef AHB_MMUX_RR_EN
  logic rr;
  assign w = (cand0 & cand1) ? rr : !cand0;
  // after a contended grant the loser gets the next tie
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) rr <= 1'b0;
    else if (grant & cand0 & cand1) rr <= !w;
`else
  assign w = !cand0;
`endif
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      owner       <= PORT0;
      dvalid      <= 1'b0;
      last_haddr  <= '0;
      last_hwrite <= 1'b0;
      last_hsize  <= '0;
    end else if (grant) begin
      owner       <= port_e'(w);
      dvalid      <= 1'b1;
      last_haddr  <= M_HADDR;
      last_hwrite <= M_HWRITE;
      last_hsize  <= M_HSIZE;
    end else if (M_HREADY) begin
      dvalid <= 1'b0;
    end
  always_comb begin
    M_HTRANS  = grant ? HTRANS_NONSEQ : HTRANS_IDLE;
    M_HADDR   = !grant ? last_haddr : w ? c1_haddr : c0_haddr;
    M_HWRITE  = !grant ? last_hwrite : w ? c1_hwrite : c0_hwrite;
    M_HSIZE   = !grant ? last_hsize : w ? c1_hsize : c0_hsize;
    M_HWDATA  = owner == PORT1 ? S1_HWDATA : S0_HWDATA;
    S0_HREADY = (owner == PORT0 && dvalid) ? M_HREADY : !pend0;
    S1_HREADY = (owner == PORT1 && dvalid) ? M_HREADY : !pend1;
    S0_HRESP  = (owner == PORT0 && dvalid) ? M_HRESP : HRESP_OKAY;
    S1_HRESP  = (owner == PORT1 && dvalid) ? M_HRESP : HRESP_OKAY;
    S0_HRDATA = M_HRDATA;
    S1_HRDATA = M_HRDATA;
  end
endmodule

// File: tb/tb_ahb_master_mux2.sv
// tb_ahb_master_mux2: directed self-checking bench for the 2:1 AHB-Lite master mux
module tb_ahb_master_mux2;
  logic        HCLK = 1'b0, HRESETn = 1'b0;
  logic [31:0] S0_HADDR, S1_HADDR, S0_HWDATA, S1_HWDATA, S0_HRDATA, S1_HRDATA;
  logic [1:0]  S0_HTRANS, S1_HTRANS, M_HTRANS;
  logic        S0_HWRITE, S1_HWRITE, S0_HREADY, S1_HREADY, S0_HRESP, S1_HRESP;
  logic [2:0]  S0_HSIZE, S1_HSIZE, M_HSIZE;
  logic [31:0] M_HADDR, M_HWDATA, M_HRDATA;
  logic        M_HWRITE, M_HREADY, M_HRESP;
  int checks = 0, errors = 0;
  always #5 HCLK = ~HCLK;
  ahb_master_mux2 dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .S0_HADDR(S0_HADDR), .S0_HTRANS(S0_HTRANS), .S0_HWRITE(S0_HWRITE), .S0_HSIZE(S0_HSIZE),
    .S0_HWDATA(S0_HWDATA), .S0_HREADY(S0_HREADY), .S0_HRDATA(S0_HRDATA), .S0_HRESP(S0_HRESP),
    .S1_HADDR(S1_HADDR), .S1_HTRANS(S1_HTRANS), .S1_HWRITE(S1_HWRITE), .S1_HSIZE(S1_HSIZE),
    .S1_HWDATA(S1_HWDATA), .S1_HREADY(S1_HREADY), .S1_HRDATA(S1_HRDATA), .S1_HRESP(S1_HRESP),
    .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS), .M_HWRITE(M_HWRITE), .M_HSIZE(M_HSIZE),
    .M_HWDATA(M_HWDATA), .M_HREADY(M_HREADY), .M_HRDATA(M_HRDATA), .M_HRESP(M_HRESP)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask
  initial begin
    logic rr_mode;
    logic f;
    logic [31:0] fa, sa;
`ifdef AHB_MMUX_RR_EN
    rr_mode = 1'b1;
`else
    rr_mode = 1'b0;
`endif
    {S0_HADDR, S1_HADDR, S0_HWDATA, S1_HWDATA, M_HRDATA} = '0;
    {S0_HTRANS, S1_HTRANS, S0_HWRITE, S1_HWRITE, M_HRESP} = '0;
    S0_HSIZE = 3'd2;
    S1_HSIZE = 3'd2;
    M_HREADY = 1'b1;
    #2;
    chk("rst_mtrans", M_HTRANS, 0);
    chk("rst_s0rdy", S0_HREADY, 1);
    chk("rst_s1rdy", S1_HREADY, 1);
    chk("rst_s0resp", S0_HRESP, 0);
    tick;
    HRESETn = 1'b1;
    tick;
    S1_HTRANS = 2'b10; S1_HADDR = 32'h2000_0010; S1_HWRITE = 1'b1;
    #1;
    chk("t1_mtrans", M_HTRANS, 2);
    chk("t1_maddr", M_HADDR, 32'h2000_0010);
    chk("t1_mwrite", M_HWRITE, 1);
    chk("t1_s1rdy_a", S1_HREADY, 1);
    tick;
    S1_HTRANS = 2'b00; S1_HWDATA = 32'hA5A5_A5A5;
    #1;
    chk("t1_mwdata", M_HWDATA, 32'hA5A5_A5A5);
    chk("t1_s1rdy_d", S1_HREADY, 1);
    chk("t1_idle", M_HTRANS, 0);
    chk("t1_hold_addr", M_HADDR, 32'h2000_0010);
    for (int k = 0; k < 4; k++) begin
      tick;
      f = rr_mode & k[0];
      fa = f ? 32'h200 : 32'h100;
      sa = f ? 32'h100 : 32'h200;
      S0_HTRANS = 2'b10; S0_HADDR = 32'h100; S0_HWRITE = 1'b0;
      S1_HTRANS = 2'b10; S1_HADDR = 32'h200; S1_HWRITE = 1'b1;
      #1;
      chk("t2_first", M_HADDR, fa);
      chk("t2_first_tr", M_HTRANS, 2);
      tick;
      S0_HTRANS = 2'b00; S1_HTRANS = 2'b00;
      S0_HWDATA = 32'h1111_1111; S1_HWDATA = 32'h2222_2222;
      M_HRDATA = 32'hCAFE_0000 + k;
      #1;
      chk("t2_second", M_HADDR, sa);
      chk("t2_second_tr", M_HTRANS, 2);
      chk("t2_loser_rdy", f ? S0_HREADY : S1_HREADY, 0);
      chk("t2_winner_rdy", f ? S1_HREADY : S0_HREADY, 1);
      chk("t2_wdata_w", M_HWDATA, f ? 32'h2222_2222 : 32'h1111_1111);
      chk("t2_s0rdata", S0_HRDATA, 32'hCAFE_0000 + k);
      tick;
      #1;
      chk("t2_loser_done", f ? S0_HREADY : S1_HREADY, 1);
      chk("t2_wdata_l", M_HWDATA, f ? 32'h1111_1111 : 32'h2222_2222);
      chk("t2_idle", M_HTRANS, 0);
    end
    tick;
    S0_HTRANS = 2'b10; S0_HADDR = 32'h400; S0_HWRITE = 1'b0;
    #1;
    chk("t4_s0_issue", M_HTRANS, 2);
    tick;
    S0_HTRANS = 2'b00; M_HREADY = 1'b0;
    S1_HTRANS = 2'b10; S1_HADDR = 32'h300; S1_HWRITE = 1'b1;
    #1;
    chk("t4_wait_idle0", M_HTRANS, 0);
    chk("t4_s0_stall", S0_HREADY, 0);
    chk("t4_s1_accept", S1_HREADY, 1);
    tick;
    S1_HTRANS = 2'b00; S1_HADDR = 32'hDEAD_0000; S1_HWRITE = 1'b0;
    #1;
    chk("t4_wait_idle1", M_HTRANS, 0);
    chk("t4_s1_parked1", S1_HREADY, 0);
    tick;
    #1;
    chk("t4_wait_idle2", M_HTRANS, 0);
    chk("t4_s1_parked2", S1_HREADY, 0);
    tick;
    M_HREADY = 1'b1;
    #1;
    chk("t4_issue_tr", M_HTRANS, 2);
    chk("t4_issue_addr", M_HADDR, 32'h300);
    chk("t4_issue_wr", M_HWRITE, 1);
    chk("t4_s0_done", S0_HREADY, 1);
    tick;
    #1;
    chk("t4_s1_data", S1_HREADY, 1);
    chk("t4_idle", M_HTRANS, 0);
    tick;
    S1_HTRANS = 2'b10; S1_HADDR = 32'h500; S1_HWRITE = 1'b0;
    #1;
    chk("t5_issue", M_HTRANS, 2);
    tick;
    S1_HTRANS = 2'b00; M_HREADY = 1'b0; M_HRESP = 1'b1;
    #1;
    chk("t5_err1_resp", S1_HRESP, 1);
    chk("t5_err1_rdy", S1_HREADY, 0);
    chk("t5_s0_okay1", S0_HRESP, 0);
    tick;
    M_HREADY = 1'b1;
    #1;
    chk("t5_err2_resp", S1_HRESP, 1);
    chk("t5_err2_rdy", S1_HREADY, 1);
    chk("t5_s0_okay2", S0_HRESP, 0);
    tick;
    M_HRESP = 1'b0;
    #1;
    chk("t5_after", S1_HRESP, 0);
    tick;
    S0_HTRANS = 2'b10; S0_HADDR = 32'h600;
    tick;
    S0_HTRANS = 2'b00; M_HREADY = 1'b0;
    S1_HTRANS = 2'b10; S1_HADDR = 32'h700;
    tick;
    S1_HTRANS = 2'b00;
    #1;
    chk("t6_parked", S1_HREADY, 0);
    #1;
    HRESETn = 1'b0; M_HREADY = 1'b1;
    #1;
    chk("t6_rst_s1rdy", S1_HREADY, 1);
    chk("t6_rst_idle", M_HTRANS, 0);
    chk("t6_rst_s0rdy", S0_HREADY, 1);
    tick;
    tick;
    HRESETn = 1'b1;
    #1;
    chk("t6_rel_idle", M_HTRANS, 0);
    chk("t6_rel_s1rdy", S1_HREADY, 1);
    tick;
    #1;
    chk("t6_no_stale", M_HTRANS, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
